div16_seq: RTL

Sequential 16-bit restoring divider for the CPU datapath, the inverse counterpart of the 16-bit adder. It accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock using a trial subtraction built from the adder arithmetic, and returns quotient and remainder with a done pulse. It is a multi-cycle ALU extension; the sequencer stalls on busy.

---
 rtl/div16_seq_pkg.sv | 6 +
 rtl/div16_seq_sub17.sv | 11 +
 rtl/div16_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/div16_seq_pkg.sv
// div16_pkg: shared width, state encoding and divide-by-zero quotient for div16_seq
package div16_pkg;
  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/div16_seq_sub17.sv
// sub17: 17-bit trial subtractor a - b built as a + ~b + 1; nonneg is the carry out (a >= b)
module sub17
  import div16_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           nonneg
);
  assign {nonneg, diff} = {1'b0, a} + {1'b0, ~b} + (WIDTH+2)'(1);
endmodule

// File: rtl/div16_seq.sv
// div16_seq: sequential 16-bit restoring divider, one quotient bit per clock.
// Define DIV16_SIGNED_EN to add the signed_op port (truncating two's complement divide).
module div16_seq
  import div16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV16_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t state, nxt;
  logic [4:0] cnt;
  logic [WIDTH:0] rem, rem_sh, diff;
  logic [2*WIDTH:0] sh;
  logic [WIDTH-1:0] quo, dsr, a_mag, b_mag, q_fix, r_fix;
  logic dz, nonneg, ld, step, fin, zero;
  assign zero = divisor == '0;
  assign sh = {rem, quo} << 1;
  assign rem_sh = sh[2*WIDTH:WIDTH];
  sub17 u_sub (.a(rem_sh), .b({1'b0, dsr}), .diff(diff), .nonneg(nonneg));
`ifdef DIV16_SIGNED_EN
  logic neg_q, neg_r, sa, sb;
  assign sa = signed_op & dividend[WIDTH-1];
  assign sb = signed_op & divisor[WIDTH-1];
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  // remainder follows the dividend sign, quotient is negative when signs differ
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {neg_q, neg_r} <= '0;
    else if (ld) {neg_q, neg_r} <= {sa ^ sb, sa};
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo;
  assign r_fix = rem[WIDTH-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (ld ? (zero ? DONE : RUN) : IDLE) :
          state == RUN  ? (cnt == 5'd15 ? DONE : RUN) : IDLE;
  // a start seen while the done pulse is up is dropped, not queued
  always_comb begin
    ld = state == IDLE && start && !done;
    step = state == RUN;
    fin = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {busy, done, div_by_zero, dz} <= '0;
      {quotient, remainder, quo, dsr} <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      done <= fin;
      if (ld) begin
        busy <= !zero;
        dz <= zero;
        dsr <= b_mag;
        quo <= zero ? dividend : a_mag;
        rem <= '0;
        cnt <= '0;
      end
      if (step) begin
        rem <= nonneg ? diff : rem_sh;
        quo <= sh[WIDTH-1:0] | WIDTH'(nonneg);
        cnt <= cnt + 5'd1;
      end
      if (fin) begin
        busy <= 1'b0;
        quotient <= dz ? DIV0_QUOTIENT : q_fix;
        remainder <= dz ? quo : r_fix;
        div_by_zero <= dz;
      end
    end
endmodule
